instr_fetch_sequencer: RTL and testbench

INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

---
 rtl/instr_fetch_sequencer.sv | 110 +++++++++++
 tb/tb_instr_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE/FETCH/EXEC/INCR over a program,
// waiting out instruction memory latency and capturing each instruction.
module instr_fetch_sequencer #(
  parameter int MAX_COUNT   = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic [9:0]  pc_in,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  state,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    INCR  = 2'd2,
    EXEC  = 2'd3
  } st_t;

  localparam logic [10:0] MAX_W = 11'(MAX_COUNT);
  localparam logic [2:0]  LAST  = 3'(MEM_LATENCY - 1);

  st_t         cur;
  st_t         nxt;
  logic [2:0]  lat_cnt;
  logic [2:0]  lat_nxt;
  logic        done_nxt;
  logic        cap;
  logic [10:0] pc_w;
  logic [10:0] pc_inc;
  logic        pc_ok;
  logic        pc_end;

  // Widen so pc_in+1 never wraps against the limit
  assign pc_w   = {1'b0, pc_in};
  assign pc_inc = pc_w + 11'd1;
  assign pc_ok  = pc_w < MAX_W;
  assign pc_end = pc_inc >= MAX_W;

  always_comb begin
    nxt      = cur;
    lat_nxt  = lat_cnt;
    done_nxt = 1'b0;
    cap      = 1'b0;
    if (halt) begin
      nxt     = IDLE;
      lat_nxt = 3'd0;
    end else begin
      unique case (cur)
        IDLE: begin
          if (start) begin
            if (pc_ok) begin
              nxt     = FETCH;
              lat_nxt = 3'd0;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        FETCH: begin
          lat_nxt = lat_cnt + 3'd1;
          if (lat_cnt == LAST) begin
            cap = 1'b1;
            nxt = EXEC;
          end
        end
        EXEC: begin
          if (!stall) nxt = INCR;
        end
        INCR: begin
          if (pc_end) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
          end else begin
            nxt     = FETCH;
            lat_nxt = 3'd0;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      lat_cnt   <= 3'd0;
      instr_out <= 16'h0000;
      done      <= 1'b0;
    end else begin
      cur     <= nxt;
      lat_cnt <= lat_nxt;
      done    <= done_nxt;
      if (cap) instr_out <= mem_rdata;
    end
  end

  assign state       = cur;
  assign busy        = (cur != IDLE);
  assign instr_valid = (cur == EXEC);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: default build plus
// MEM_LATENCY=1 and MEM_LATENCY=7 instances.
module tb_instr_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic [9:0]  pc;
  logic        pc_ld;
  logic [15:0] mem_rdata;
  logic [1:0]  state;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        busy;
  logic        done;

  logic        s1;
  logic        s7;
  logic        x_halt;
  logic [15:0] x_rdata = 16'h1000;
  logic [1:0]  st1;
  logic [1:0]  st7;
  logic [15:0] ins1;
  logic [15:0] ins7;
  logic        v1, v7, b1, b7, d1, d7;

  int n_chk = 0;
  int n_pass = 0;

  instr_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .stall(stall), .pc_in(pc), .mem_rdata(mem_rdata),
    .state(state), .instr_out(instr_out),
    .instr_valid(instr_valid), .busy(busy), .done(done)
  );

  instr_fetch_sequencer #(.MAX_COUNT(4), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .halt(x_halt),
    .stall(1'b0), .pc_in(10'd0), .mem_rdata(x_rdata),
    .state(st1), .instr_out(ins1),
    .instr_valid(v1), .busy(b1), .done(d1)
  );

  instr_fetch_sequencer #(.MAX_COUNT(4), .MEM_LATENCY(7)) u7 (
    .clk(clk), .rst_n(rst_n), .start(s7), .halt(x_halt),
    .stall(1'b0), .pc_in(10'd0), .mem_rdata(x_rdata),
    .state(st7), .instr_out(ins7),
    .instr_valid(v7), .busy(b7), .done(d7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: advances on each INCR cycle
  always @(posedge clk) begin
    if (pc_ld) pc <= 10'd0;
    else if (state == 2'd2) pc <= pc + 10'd1;
  end

  assign mem_rdata = 16'hA000 + {6'd0, pc};

  always @(posedge clk) x_rdata <= x_rdata + 16'h0101;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic reload_pc();
    pc_ld = 1'b1;
    tick();
    pc_ld = 1'b0;
  endtask

  int          st_b [19];
  int          in_b [19];
  int          st_h [8];
  int          n;
  logic [15:0] last;
  logic [15:0] e_ins;

  initial begin
    st_b = '{1,1,3,2,1,1,3,3,3,3,2,1,1,3,2,1,1,3,2};
    in_b = '{3,3,0,0,0,0,1,1,1,1,1,1,1,2,2,2,2,3,3};
    st_h = '{1,1,3,2,1,1,3,2};
    rst_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    stall = 1'b0;
    pc_ld = 1'b1;
    s1 = 1'b0;
    s7 = 1'b0;
    x_halt = 1'b0;
    tick();
    tick();
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    rst_n = 1'b1;
    pc_ld = 1'b0;
    tick();
    chk("idle_wait", {14'd0, state}, 16'd0);

    // Full run, no stall
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e_ins = (i < 2) ? 16'h0000 : 16'hA000 + 16'((i - 2) / 4);
      chk("run_state", {14'd0, state}, 16'(st_h[i % 4]));
      chk("run_instr", instr_out, e_ins);
      chk("run_valid", {15'd0, instr_valid}, 16'(st_h[i % 4] == 3));
      chk("run_busy", {15'd0, busy}, 16'd1);
      chk("run_done", {15'd0, done}, 16'd0);
      tick();
    end
    chk("run_end_state", {14'd0, state}, 16'd0);
    chk("run_end_done", {15'd0, done}, 16'd1);
    tick();
    chk("run_done_pulse", {15'd0, done}, 16'd0);

    // Empty program: pc already at the limit
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_state", {14'd0, state}, 16'd0);
    chk("empty_done", {15'd0, done}, 16'd1);
    tick();
    chk("empty_state2", {14'd0, state}, 16'd0);
    chk("empty_done2", {15'd0, done}, 16'd0);

    // Stall held over the second EXEC; stray stall in FETCH/INCR
    reload_pc();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      stall = (i == 0) || (i == 3) || (i >= 6 && i <= 8);
      chk("stl_state", {14'd0, state}, 16'(st_b[i]));
      chk("stl_instr", instr_out, 16'hA000 + 16'(in_b[i]));
      chk("stl_valid", {15'd0, instr_valid}, 16'(st_b[i] == 3));
      chk("stl_done", {15'd0, done}, 16'd0);
      tick();
    end
    stall = 1'b0;
    chk("stl_end_state", {14'd0, state}, 16'd0);
    chk("stl_end_done", {15'd0, done}, 16'd1);
    tick();

    // Halt during the third FETCH, then resume
    reload_pc();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("hlt_state", {14'd0, state}, 16'(st_h[i]));
      tick();
    end
    chk("hlt_fetch3", {14'd0, state}, 16'd1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hlt_state0", {14'd0, state}, 16'd0);
    chk("hlt_busy", {15'd0, busy}, 16'd0);
    chk("hlt_instr", instr_out, 16'hA001);
    for (int i = 0; i < 3; i++) begin
      chk("hlt_nodone", {15'd0, done}, 16'd0);
      tick();
    end
    start = 1'b1;
    halt = 1'b1;
    tick();
    start = 1'b0;
    halt = 1'b0;
    chk("sh_state", {14'd0, state}, 16'd0);
    chk("sh_done", {15'd0, done}, 16'd0);
    tick();
    chk("sh_state2", {14'd0, state}, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("res_state", {14'd0, state}, 16'(st_h[i]));
      if (st_h[i] == 3)
        chk("res_instr", instr_out, 16'hA002 + 16'(i / 4));
      chk("res_done", {15'd0, done}, 16'd0);
      tick();
    end
    chk("res_end_state", {14'd0, state}, 16'd0);
    chk("res_end_done", {15'd0, done}, 16'd1);
    tick();

    // Latency 1 and 7 builds: FETCH length and capture edge
    for (int k = 0; k < 2; k++) begin
      n = 0;
      last = '0;
      if (k == 0) s1 = 1'b1;
      else s7 = 1'b1;
      tick();
      s1 = 1'b0;
      s7 = 1'b0;
      while (((k == 0) ? st1 : st7) == 2'd1 && n < 20) begin
        last = x_rdata;
        tick();
        n++;
      end
      chk("ml_fetch_len", 16'(n), (k == 0) ? 16'd1 : 16'd7);
      chk("ml_state", {14'd0, (k == 0) ? st1 : st7}, 16'd3);
      chk("ml_capture", (k == 0) ? ins1 : ins7, last);
      tick();
      chk("ml_hold", (k == 0) ? ins1 : ins7, last);
      x_halt = 1'b1;
      tick();
      x_halt = 1'b0;
      chk("ml_halted", {14'd0, (k == 0) ? st1 : st7}, 16'd0);
    end

    // Asynchronous reset in the middle of EXEC
    reload_pc();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ar_exec", {14'd0, state}, 16'd3);
    chk("ar_instr", instr_out, 16'hA000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", {14'd0, state}, 16'd0);
    chk("ar_instr0", instr_out, 16'h0000);
    chk("ar_done", {15'd0, done}, 16'd0);
    chk("ar_valid", {15'd0, instr_valid}, 16'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_idle", {14'd0, state}, 16'd0);
    tick();
    chk("ar_idle2", {14'd0, state}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
